dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, data memory address width.
REQ-002 Parameter DATA_W, default 16, data memory word width.
REQ-003 Clk  input  1  system clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset.
REQ-005 Cpu_Req  input  1  processor FSM access request; held until Cpu_Gnt.
REQ-006 Cpu_Wr  input  1  processor write (1) / read (0); valid with Cpu_Req.
REQ-007 Cpu_Addr  input  ADDR_W  processor address; valid with Cpu_Req.
REQ-008 Cpu_WData  input  DATA_W  processor write data; valid with Cpu_Req.
REQ-009 Cpu_Gnt  output  1  one-cycle pulse; processor request accepted.
REQ-010 Cpu_RData  output  DATA_W  processor read data; valid when Cpu_RValid.
REQ-011 Cpu_RValid  output  1  one-cycle pulse; processor read data valid.
REQ-012 Dbg_Req, Dbg_Wr, Dbg_Addr, Dbg_WData, Dbg_Gnt, Dbg_RData, Dbg_RValid: debug/loader port, same directions, widths, meanings as Cpu_* set.
REQ-013 Mem_Addr  output  ADDR_W  registered address to synchronous data RAM.
REQ-014 Mem_WData  output  DATA_W  registered write data to RAM.
REQ-015 Mem_Wr  output  1  registered RAM write enable.
REQ-016 Mem_RData  input  DATA_W  RAM output; valid one cycle after address presented.
REQ-017 Arb_State  output  2  current state code, for debug/monitor.

Function
REQ-018 States: IDLE=0, ACCESS=1, RESP=2; code 3 unused, SHALL return to IDLE next cycle.
REQ-019 IDLE: no request -> IDLE; any request -> ACCESS, latching winner's Wr/Addr/WData into Mem_* and asserting winner's Gnt during ACCESS.
REQ-020 Latency: Req high in IDLE cycle N -> Gnt and Mem_* valid in cycle N+1; read -> RValid in cycle N+2.
REQ-021 ACCESS, write: Mem_Wr=1 for exactly this cycle; next state chosen as from IDLE (back-to-back writes allowed, 1 per cycle).
REQ-022 ACCESS, read: Mem_Wr=0; next state RESP.
REQ-023 RESP: owner's RValid=1, owner's RData = Mem_RData; next state chosen as from IDLE.
REQ-024 Non-owner RData SHALL hold its last value; non-owner RValid and Gnt SHALL be 0.
REQ-025 Granted requester's Req SHALL be ignored in its Gnt cycle (no double grant before requester deasserts).
REQ-026 Arbitration: two-way round-robin; single requester always wins; simultaneous requests -> requester not granted last wins.
REQ-027 Last-grant pointer updates only on a grant.
REQ-028 Requests arriving during ACCESS (read) or RESP are held by requester, not lost; evaluated at next decision point.
REQ-029 Mem_Wr SHALL never be 1 outside ACCESS; Cpu_Gnt and Dbg_Gnt never both 1.

Reset
REQ-030 Reset low: state IDLE, all Gnt/RValid/Mem_Wr = 0, Mem_Addr/Mem_WData/RData = 0, last-grant pointer = Dbg (Cpu wins first tie), all immediately, independent of Clk.
REQ-031 Reset mid-ACCESS or mid-RESP: transaction dropped, no write issued after assertion, no RValid generated.
REQ-032 First decision after release on first rising edge with Reset high.

Structure
REQ-033 Package dmem_arb_pkg holds state enum (IDLE/ACCESS/RESP), owner enum (CPU/DBG), default widths.
REQ-034 Sub-module dmem_rr_pick: combinational two-way round-robin picker (reqs, last pointer -> grant one-hot); rest in dmem_arbiter.

Verification
REQ-035 Cpu write Addr=0x10, WData=0xBEEF alone -> Cpu_Gnt cycle N+1, Mem_Wr=1, Mem_Addr=0x10, Mem_WData=0xBEEF that cycle.
REQ-036 Cpu read 0x10 after REQ-035 -> Cpu_RValid at N+2, Cpu_RData=0xBEEF; Dbg_RValid stays 0.
REQ-037 Cpu and Dbg read simultaneously from reset -> Cpu granted first, Dbg granted at first decision after Cpu RESP; each RData correct.
REQ-038 Both request continuous writes for 6 grants -> grants alternate CPU,DBG,CPU,DBG,CPU,DBG, one write per cycle, Gnts never overlap.
REQ-039 Reset low during ACCESS of Dbg write to 0x20 -> Mem_Wr drops immediately, RAM[0x20] unchanged, state 0 after release.
REQ-040 Req held high through Gnt cycle and one extra cycle -> exactly one grant per assertion as defined by REQ-025, no duplicate Mem_Wr.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared state/owner encodings and default widths for the data memory arbiter
package dmem_arb_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;
  typedef enum logic {CPU = 1'b0, DBG = 1'b1} owner_t;
endpackage

// File: rtl/dmem_rr_pick.sv
// dmem_rr_pick: two-way round-robin picker; req/gnt bit0 = cpu, bit1 = dbg; on a tie the side not granted last wins
module dmem_rr_pick
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_t     last,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] & (~req[1] | (last == DBG));
  assign gnt[1] = req[1] & (~req[0] | (last == CPU));
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: arbitrates cpu and debug ports onto one synchronous data RAM
// ports: clk, rst_n (async active-low); cpu_*/dbg_* request ports (req/wr/addr/wdata in, gnt/rdata/rvalid out);
//        mem_addr/mem_wdata/mem_wr registered to RAM, mem_rdata from RAM; arb_state current state code
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              dbg_req,
  input  logic              dbg_wr,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              dbg_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [1:0]        arb_state
);
  state_t state;
  owner_t owner, last;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [1:0] req_m, gnt;
  logic decide;
  // an ACCESS cycle with mem_wr low is a read, which must go through RESP before the next decision
  assign decide = (state == IDLE) | (state == RESP) | ((state == ACCESS) & mem_wr);
  // the owner still holds req during its grant cycle; that req is already served
  assign req_m = {dbg_req & ~((state == ACCESS) & (owner == DBG)),
                  cpu_req & ~((state == ACCESS) & (owner == CPU))};
  dmem_rr_pick u_pick (.req(req_m), .last(last), .gnt(gnt));
  // RAM data appears during RESP, so it is passed straight through and captured for holding
  assign cpu_rdata = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign dbg_rdata = dbg_rvalid ? mem_rdata : dbg_rdata_q;
  assign arb_state = state;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      owner       <= CPU;
      last        <= DBG;
      cpu_gnt     <= 1'b0;
      dbg_gnt     <= 1'b0;
      cpu_rvalid  <= 1'b0;
      dbg_rvalid  <= 1'b0;
      mem_wr      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_wr     <= 1'b0;
      if (cpu_rvalid) cpu_rdata_q <= mem_rdata;
      if (dbg_rvalid) dbg_rdata_q <= mem_rdata;
      if (decide && |gnt) begin
        state     <= ACCESS;
        owner     <= gnt[1] ? DBG : CPU;
        last      <= gnt[1] ? DBG : CPU;
        cpu_gnt   <= gnt[0];
        dbg_gnt   <= gnt[1];
        mem_wr    <= gnt[1] ? dbg_wr : cpu_wr;
        mem_addr  <= gnt[1] ? dbg_addr : cpu_addr;
        mem_wdata <= gnt[1] ? dbg_wdata : cpu_wdata;
      end else if (state == ACCESS && !mem_wr) begin
        state      <= RESP;
        cpu_rvalid <= owner == CPU;
        dbg_rvalid <= owner == DBG;
      end else begin
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: self-checking bench for dmem_arbiter with a behavioural RAM and transaction-level reference model
module tb_dmem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic cpu_req, cpu_wr, cpu_gnt, cpu_rvalid;
  logic dbg_req, dbg_wr, dbg_gnt, dbg_rvalid;
  logic [AW-1:0] cpu_addr, dbg_addr, mem_addr;
  logic [DW-1:0] cpu_wdata, dbg_wdata, cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic mem_wr;
  logic [1:0] arb_state;
  logic [DW-1:0] ram [256];
  int errs = 0;
  int checks = 0;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .dbg_req(dbg_req), .dbg_wr(dbg_wr), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rdata(dbg_rdata), .dbg_rvalid(dbg_rvalid),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wr(mem_wr), .mem_rdata(mem_rdata),
    .arb_state(arb_state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  always @(negedge clk) begin
    checks++;
    if ((cpu_gnt && dbg_gnt) || (mem_wr && arb_state != 2'd1)) begin
      errs++;
      $display("FAIL invariant: gnt=%b%b mem_wr=%b state=%0d, required no double grant and mem_wr only in ACCESS",
               cpu_gnt, dbg_gnt, mem_wr, arb_state);
    end
  end

  task automatic idle_inputs();
    cpu_req = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_wr = 0; dbg_addr = 0; dbg_wdata = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    #13 rst_n = 0;
    #1;
    checks++;
    if ({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_wr, arb_state, mem_addr, mem_wdata, cpu_rdata, dbg_rdata} !== '0) begin
      errs++;
      $display("FAIL reset_async: gnt=%b%b rv=%b%b wr=%b st=%0d addr=%h wd=%h rd=%h/%h, required all zero",
               cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_wr, arb_state, mem_addr, mem_wdata, cpu_rdata, dbg_rdata);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (arb_state !== 2'd0 || cpu_gnt !== 1'b0) begin
      errs++;
      $display("FAIL reset_idle: state=%0d gnt=%b, required 0/0", arb_state, cpu_gnt);
    end
  endtask

  task automatic test_write_read();
    cpu_req = 1; cpu_wr = 1; cpu_addr = 8'h10; cpu_wdata = 16'hBEEF;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_wr, arb_state, mem_addr, mem_wdata} !== {3'b101, 2'd1, 8'h10, 16'hBEEF}) begin
      errs++;
      $display("FAIL cpu_write: gnt=%b%b wr=%b st=%0d addr=%h wd=%h, required 1 0 1 1 10 beef",
               cpu_gnt, dbg_gnt, mem_wr, arb_state, mem_addr, mem_wdata);
    end
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if (mem_wr !== 1'b0 || arb_state !== 2'd0 || cpu_gnt !== 1'b0) begin
      errs++;
      $display("FAIL cpu_write_done: wr=%b st=%0d gnt=%b, required 0 0 0", mem_wr, arb_state, cpu_gnt);
    end
    cpu_req = 1; cpu_wr = 0; cpu_addr = 8'h10;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, mem_wr, arb_state, mem_addr} !== {2'b10, 2'd1, 8'h10}) begin
      errs++;
      $display("FAIL cpu_read_gnt: gnt=%b wr=%b st=%0d addr=%h, required 1 0 1 10", cpu_gnt, mem_wr, arb_state, mem_addr);
    end
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, dbg_rvalid, arb_state, cpu_rdata} !== {2'b10, 2'd2, 16'hBEEF}) begin
      errs++;
      $display("FAIL cpu_read_data: rv=%b%b st=%0d rd=%h, required 1 0 2 beef", cpu_rvalid, dbg_rvalid, arb_state, cpu_rdata);
    end
    @(negedge clk);
    checks++;
    if (cpu_rvalid !== 1'b0 || cpu_rdata !== 16'hBEEF || dbg_rvalid !== 1'b0) begin
      errs++;
      $display("FAIL cpu_read_hold: rv=%b rd=%h dbg_rv=%b, required 0 beef 0", cpu_rvalid, cpu_rdata, dbg_rvalid);
    end
  endtask

  task automatic test_tie();
    ram[8'h40] = 16'h1111;
    ram[8'h41] = 16'h2222;
    do_reset();
    cpu_req = 1; cpu_wr = 0; cpu_addr = 8'h40;
    dbg_req = 1; dbg_wr = 0; dbg_addr = 8'h41;
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_addr} !== {2'b10, 8'h40}) begin
      errs++;
      $display("FAIL tie_first: gnt=%b%b addr=%h, required cpu 40", cpu_gnt, dbg_gnt, mem_addr);
    end
    cpu_req = 0;
    @(negedge clk);
    checks++;
    if ({cpu_rvalid, dbg_rvalid, dbg_gnt, cpu_rdata} !== {3'b100, 16'h1111}) begin
      errs++;
      $display("FAIL tie_cpu_resp: rv=%b%b dgnt=%b rd=%h, required 1 0 0 1111", cpu_rvalid, dbg_rvalid, dbg_gnt, cpu_rdata);
    end
    @(negedge clk);
    checks++;
    if ({cpu_gnt, dbg_gnt, mem_addr} !== {2'b01, 8'h41}) begin
      errs++;
      $display("FAIL tie_second: gnt=%b%b addr=%h, required dbg 41", cpu_gnt, dbg_gnt, mem_addr);
    end
    dbg_req = 0;
    @(negedge clk);
    checks++;
    if ({dbg_rvalid, cpu_rvalid, dbg_rdata, cpu_rdata} !== {2'b10, 16'h2222, 16'h1111}) begin
      errs++;
      $display("FAIL tie_dbg_resp: rv=%b%b rd=%h/%h, required dbg 2222 cpu 1111", cpu_rvalid, dbg_rvalid, cpu_rdata, dbg_rdata);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int ci = 0;
    int di = 0;
    cpu_req = 1; cpu_wr = 1; cpu_addr = 8'h50; cpu_wdata = 16'hC000;
    dbg_req = 1; dbg_wr = 1; dbg_addr = 8'h60; dbg_wdata = 16'hD000;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      checks++;
      if ((k % 2 == 0) ? ({cpu_gnt, dbg_gnt, mem_wr, mem_addr, mem_wdata} !== {3'b101, 8'(8'h50 + ci), 16'(16'hC000 + ci)})
                       : ({cpu_gnt, dbg_gnt, mem_wr, mem_addr, mem_wdata} !== {3'b011, 8'(8'h60 + di), 16'(16'hD000 + di)})) begin
        errs++;
        $display("FAIL b2b_%0d: gnt=%b%b wr=%b addr=%h wd=%h, required %s grant with write", k,
                 cpu_gnt, dbg_gnt, mem_wr, mem_addr, mem_wdata, (k % 2 == 0) ? "cpu" : "dbg");
      end
      if (cpu_gnt) begin ci++; cpu_addr = 8'(8'h50 + ci); cpu_wdata = 16'(16'hC000 + ci); end
      if (dbg_gnt) begin di++; dbg_addr = 8'(8'h60 + di); dbg_wdata = 16'(16'hD000 + di); end
    end
    idle_inputs();
    repeat (2) @(negedge clk);
    checks++;
    if ({ram[8'h50], ram[8'h52], ram[8'h61]} !== {16'hC000, 16'hC002, 16'hD001}) begin
      errs++;
      $display("FAIL b2b_ram: %h %h %h, required c000 c002 d001", ram[8'h50], ram[8'h52], ram[8'h61]);
    end
  endtask

  task automatic test_hold();
    int grants = 0;
    int writes = 0;
    dbg_req = 1; dbg_wr = 1; dbg_addr = 8'h70; dbg_wdata = 16'h7777;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      grants += int'(dbg_gnt) + int'(cpu_gnt);
      writes += int'(mem_wr);
      if (dbg_gnt) dbg_req = 0;
    end
    checks++;
    if (grants != 1 || writes != 1) begin
      errs++;
      $display("FAIL hold_single: grants=%0d writes=%0d, required 1 1", grants, writes);
    end
  endtask

  task automatic test_random();
    int g = -1;
    int r = -1;
    int last = 1;
    int ng, nr;
    bit gread = 0;
    bit e_wr = 0;
    bit c, d;
    logic [AW-1:0] e_addr = '0;
    logic [DW-1:0] e_wd = '0;
    logic [DW-1:0] e_rd [2];
    logic [DW-1:0] mm [256];
    bit rq [2];
    bit rw [2];
    logic [AW-1:0] ra [2];
    logic [DW-1:0] rd [2];
    logic [1:0] st;
    logic [62:0] got, exp_v;
    do_reset();
    for (int i = 0; i < 256; i++) mm[i] = ram[i];
    e_rd[0] = '0; e_rd[1] = '0;
    rq[0] = 0; rq[1] = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      if (cyc > 0) @(negedge clk);
      st = (g >= 0) ? 2'd1 : (r >= 0) ? 2'd2 : 2'd0;
      exp_v = {g == 0, g == 1, (g >= 0) && e_wr, r == 0, r == 1, st, e_addr, e_wd, e_rd[0], e_rd[1]};
      got = {cpu_gnt, dbg_gnt, mem_wr, cpu_rvalid, dbg_rvalid, arb_state, mem_addr, mem_wdata, cpu_rdata, dbg_rdata};
      checks++;
      if (got !== exp_v) begin
        errs++;
        $display("FAIL rand_cyc%0d: got=%h exp=%h (gnt,gnt,wr,rv,rv,st,addr,wd,rd,rd)", cyc, got, exp_v);
      end
      for (int i = 0; i < 2; i++) begin
        if ((rq[i] && g == i) || !rq[i]) begin
          rq[i] = (rq[i] && g == i) ? ($urandom_range(1) == 1) : ($urandom_range(2) == 0);
          rw[i] = $urandom_range(1) == 1;
          ra[i] = 8'($urandom_range(15));
          rd[i] = 16'($urandom);
        end
      end
      cpu_req = rq[0]; cpu_wr = rw[0]; cpu_addr = ra[0]; cpu_wdata = rd[0];
      dbg_req = rq[1]; dbg_wr = rw[1]; dbg_addr = ra[1]; dbg_wdata = rd[1];
      nr = (g >= 0 && gread) ? g : -1;
      if (nr >= 0) e_rd[nr] = mm[e_addr];
      ng = -1;
      if (!(g >= 0 && gread)) begin
        c = rq[0] && g != 0;
        d = rq[1] && g != 1;
        ng = (c && d) ? ((last == 0) ? 1 : 0) : c ? 0 : d ? 1 : -1;
        if (ng >= 0) begin
          last = ng; e_wr = rw[ng]; e_addr = ra[ng]; e_wd = rd[ng]; gread = !rw[ng];
          if (rw[ng]) mm[ra[ng]] = rd[ng];
        end
      end
      g = ng;
      r = nr;
    end
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    ram[8'h20] = 16'h1234;
    dbg_req = 1; dbg_wr = 1; dbg_addr = 8'h20; dbg_wdata = 16'hDEAD;
    @(negedge clk);
    checks++;
    if ({dbg_gnt, mem_wr, mem_addr} !== {2'b11, 8'h20}) begin
      errs++;
      $display("FAIL rstmid_access: gnt=%b wr=%b addr=%h, required 1 1 20", dbg_gnt, mem_wr, mem_addr);
    end
    #1 rst_n = 0;
    #1;
    checks++;
    if ({mem_wr, dbg_gnt, arb_state} !== 4'b0) begin
      errs++;
      $display("FAIL rstmid_drop: wr=%b gnt=%b st=%0d, required 0 0 0", mem_wr, dbg_gnt, arb_state);
    end
    idle_inputs();
    @(negedge clk);
    checks++;
    if (ram[8'h20] !== 16'h1234) begin
      errs++;
      $display("FAIL rstmid_ram: ram[20]=%h, required 1234", ram[8'h20]);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if ({arb_state, dbg_rvalid, cpu_rvalid} !== 4'b0) begin
      errs++;
      $display("FAIL rstmid_release: st=%0d rv=%b%b, required 0 0 0", arb_state, cpu_rvalid, dbg_rvalid);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 16'(i * 3);
    test_reset();
    test_write_read();
    test_tie();
    test_back_to_back();
    test_hold();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
